uart_serial_tx: RTL and testbench
=================================

Name: uart_serial_tx

Overview:
Serial-line transmitter for the terminal UART. It consumes the one-cycle byte-write pulses the terminal MMIO block produces on a TXDATA store, buffers them in a small FIFO, and serializes each byte onto a physical TX pin as an 8N1 asynchronous frame. It sits between the terminal UART register block and the board-level TX pad, and replaces the simulation-only host hook on the transmit side.

Parameters:
- CLKS_PER_BIT, default 16: clock cycles per serial bit. Must be ≥2.
- FIFO_DEPTH, default 4: byte buffer entries. Must be a power of two and ≥2.
- STOP_BITS, default 1: number of stop bits, 1 or 2.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous active-high reset
- i_valid  in  1  one-cycle byte write strike
- i_data  in  BYTE_WIDTH  byte to transmit; sampled only when i_valid is high
- o_txd  out  1  serial line, registered, idle high
- o_full  out  1  FIFO holds FIFO_DEPTH entries
- o_busy  out  1  FIFO non-empty or frame in progress
- o_level  out  $clog2(FIFO_DEPTH+1)  current FIFO occupancy
- o_overflow  out  1  one-cycle pulse when a write is dropped

Behaviour:
- Clock and reset: one clock, i_clk. Reset i_rst is synchronous and active-high.
- Reset values: o_txd=1, o_full=0, o_busy=0, o_level=0, o_overflow=0, FSM=IDLE, baud counter=0, FIFO empty. Reset applied mid-frame truncates the frame. o_txd is high from the cycle after the reset edge. Buffered bytes are discarded.
- Push: at each edge with i_valid=1 and o_full=0, i_data is written at the tail and the level increments.
  - If i_valid=1 and o_full=1, the byte is dropped, the FIFO is unchanged, and o_overflow=1 for the next cycle only.
  - o_full is evaluated on the current level. A pop on the same edge does not admit the push.
- Pop: occurs only on the edge that starts a frame. It loads the head into the shift register and decrements the level.
  - A simultaneous push and pop leaves the level unchanged.
- Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, START, DATA, PARITY (present only with the macro), STOP.
  - IDLE: o_txd=1. If the level is >0 at an edge, pop, clear the baud counter, and go to START.
  - START: o_txd=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: o_txd = shift[0], LSB first. Each bit lasts CLKS_PER_BIT cycles. Shift right after each bit. After bit 7, go to PARITY if present, else STOP.
  - STOP: o_txd=1 for STOP_BITS*CLKS_PER_BIT cycles. At its final cycle:
    - if the level is >0, pop and go directly to START with no idle gap;
    - else go to IDLE.
- Baud counter: counts 0..CLKS_PER_BIT-1 and wraps. A state or bit advances on the wrap edge.
- o_txd is a registered function of next state and next shift bit. Output is glitch-free with no combinational path from inputs.
- Latency: i_valid is high in cycle N into an empty, idle block. The FIFO is written at the end of cycle N, the pop happens at the end of N+1, and o_txd=0 from cycle N+2.
- Frame length: (1+8+STOP_BITS)*CLKS_PER_BIT cycles, plus CLKS_PER_BIT when parity is present.
- o_busy = (FSM≠IDLE) || (level≠0).
- o_full = (level==FIFO_DEPTH).
- o_level is registered.

Optional Feature:
UART_TX_PARITY_EN.
- Defined: PARITY state is inserted between DATA and STOP. o_txd = XOR of the 8 data bits (even parity) for CLKS_PER_BIT cycles. The frame is 8E1/8E2.
- Undefined: no PARITY state, no parity logic, 8N1/8N2 frames.

Test Plan:
- Reset, then idle for 100 cycles (CLKS_PER_BIT=4) -> o_txd=1, o_busy=0, o_level=0 throughout.
- Single write 0xA5 in cycle N, CLKS_PER_BIT=4 -> o_txd=0 for cycles N+2..N+5, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then stop high 4 cycles. o_busy drops after cycle N+41.
- Writes of 0x01, 0x02, 0x03 on consecutive cycles -> three frames back-to-back. The next start bit follows the stop bit with zero idle cycles. Peak o_level=2.
- With FIFO_DEPTH=4, six consecutive writes while idle -> first pop occurs; writes 1..5 accepted (level reaches 4, o_full=1); write 6 dropped, with o_overflow=1 for exactly one cycle. Five frames are emitted.
- Reset asserted mid-DATA of a 0x00 frame -> o_txd=1 the cycle after reset. The FIFO is emptied and no further frame is emitted.
- With UART_TX_PARITY_EN defined, write 0x07 -> parity bit=1. Write 0x03 -> parity bit=0. Both frames are 11*CLKS_PER_BIT cycles long.

Source files
------------

// File: rtl/uart_serial_tx.sv
// rtl/uart_serial_tx.sv - buffered UART transmitter, 8N1/8N2 frames by default.
// Define UART_TX_PARITY_EN to insert an even-parity bit (8E1/8E2).
module uart_serial_tx #(
   parameter int CLKS_PER_BIT = 16,
   parameter int FIFO_DEPTH   = 4,
   parameter int STOP_BITS    = 1,
   localparam int BYTE_WIDTH  = 8,
   localparam int LVL_W       = $clog2(FIFO_DEPTH + 1)
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_valid,
   input  logic [BYTE_WIDTH-1:0] i_data,
   output logic                  o_txd,
   output logic                  o_full,
   output logic                  o_busy,
   output logic [LVL_W-1:0]      o_level,
   output logic                  o_overflow
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [2:0]       STOP_LAST = 3'(STOP_BITS - 1);
   localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(FIFO_DEPTH);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_START  = 3'd1;
   localparam logic [2:0] S_DATA   = 3'd2;
   localparam logic [2:0] S_STOP   = 3'd4;
`ifdef UART_TX_PARITY_EN
   localparam logic [2:0] S_PARITY = 3'd3;
`endif

   logic [BYTE_WIDTH-1:0] mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
   logic [LVL_W-1:0]      level_q, level_d;
   logic                  ovf_q;
   logic [2:0]            state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [2:0]            bit_q, bit_d;
   logic [BYTE_WIDTH-1:0] shift_q, shift_d;
   logic                  txd_q, txd_d;
   logic                  full, push, pop, baud_wrap;
`ifdef UART_TX_PARITY_EN
   logic                  par_q, par_d;
`endif

   assign full = (level_q == LVL_FULL);
   assign push = i_valid && !full;

   // bit_q indexes data bits in DATA and stop bits in STOP
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      bit_d     = bit_q;
      shift_d   = shift_q;
      pop       = 1'b0;
      baud_wrap = (cnt_q == CNT_LAST);
      if (state_q != S_IDLE) begin
         cnt_d = baud_wrap ? '0 : cnt_q + CNT_W'(1);
      end
      case (state_q)
         S_IDLE: begin
            if (level_q != '0) begin
               pop     = 1'b1;
               state_d = S_START;
               cnt_d   = '0;
            end
         end
         S_START: begin
            if (baud_wrap) begin
               state_d = S_DATA;
               bit_d   = '0;
            end
         end
         S_DATA: begin
            if (baud_wrap) begin
               shift_d = {1'b0, shift_q[BYTE_WIDTH-1:1]};
               bit_d   = bit_q + 3'd1;
               if (bit_q == 3'd7) begin
                  bit_d = '0;
`ifdef UART_TX_PARITY_EN
                  state_d = S_PARITY;
`else
                  state_d = S_STOP;
`endif
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         S_PARITY: begin
            if (baud_wrap) begin
               state_d = S_STOP;
               bit_d   = '0;
            end
         end
`endif
         S_STOP: begin
            if (baud_wrap) begin
               bit_d = bit_q + 3'd1;
               if (bit_q == STOP_LAST) begin
                  bit_d = '0;
                  if (level_q != '0) begin
                     pop     = 1'b1;
                     state_d = S_START;
                  end else begin
                     state_d = S_IDLE;
                  end
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
      if (pop) begin
         shift_d = mem_q[rd_ptr_q];
      end
   end

`ifdef UART_TX_PARITY_EN
   assign par_d = pop ? ^mem_q[rd_ptr_q] : par_q;
`endif

   // Line value is decided from the next state so o_txd comes straight off a flop
   always_comb begin
      case (state_d)
         S_START: txd_d = 1'b0;
         S_DATA:  txd_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
         S_PARITY: txd_d = par_d;
`endif
         default: txd_d = 1'b1;
      endcase
   end

   always_comb begin
      case ({push, pop})
         2'b10:   level_d = level_q + LVL_W'(1);
         2'b01:   level_d = level_q - LVL_W'(1);
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         bit_q    <= '0;
         shift_q  <= '0;
         txd_q    <= 1'b1;
         level_q  <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         ovf_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
         par_q    <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         txd_q   <= txd_d;
         level_q <= level_d;
         ovf_q   <= i_valid && full;
`ifdef UART_TX_PARITY_EN
         par_q   <= par_d;
`endif
         if (push) begin
            wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= i_data;
      end
   end

   assign o_txd      = txd_q;
   assign o_full     = full;
   assign o_busy     = (state_q != S_IDLE) || (level_q != '0);
   assign o_level    = level_q;
   assign o_overflow = ovf_q;

endmodule

// File: tb/tb_uart_serial_tx.sv
// tb/tb_uart_serial_tx.sv - uart_serial_tx bench: frame-level line model plus directed literal checks.
module tb_uart_serial_tx;

   localparam int CPB   = 4;
   localparam int DEPTH = 4;
   localparam int NSTOP = 1;
`ifdef UART_TX_PARITY_EN
   localparam int NPAR = 1;
`else
   localparam int NPAR = 0;
`endif
   localparam int FRAME = (1 + 8 + NPAR + NSTOP) * CPB;

   logic       clk   = 1'b0;
   logic       rst   = 1'b1;
   logic       valid = 1'b0;
   logic [7:0] data  = 8'h00;
   logic       txd, full, busy, ovf;
   logic [2:0] level;

   uart_serial_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .STOP_BITS(NSTOP)) dut (
      .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_data(data),
      .o_txd(txd), .o_full(full), .o_busy(busy), .o_level(level), .o_overflow(ovf)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         if (n_bad <= 40) $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Model: FIFO of accepted bytes and a queue of future line values, one per cycle.
   byte unsigned m_q[$];
   bit           m_line[$];
   bit           m_txd    = 1'b1;
   bit           m_active = 1'b0;
   bit           m_ovf    = 1'b0;
   bit           m_ready  = 1'b0;

   always @(posedge clk) begin : model
      bit           was_full;
      byte unsigned b;
      if (rst) begin
         m_q.delete();
         m_line.delete();
         m_txd    = 1'b1;
         m_active = 1'b0;
         m_ovf    = 1'b0;
         m_ready  = 1'b1;
      end else begin
         was_full = (m_q.size() == DEPTH);
         if (m_line.size() == 0 && m_q.size() > 0) begin
            b = m_q.pop_front();
            for (int k = 0; k < CPB; k++) m_line.push_back(1'b0);
            for (int i = 0; i < 8; i++)
               for (int k = 0; k < CPB; k++) m_line.push_back(b[i]);
            for (int k = 0; k < NPAR * CPB; k++) m_line.push_back(^b);
            for (int k = 0; k < NSTOP * CPB; k++) m_line.push_back(1'b1);
         end
         if (valid && !was_full) m_q.push_back(data);
         m_ovf = valid && was_full;
         if (m_line.size() > 0) begin
            m_txd    = m_line.pop_front();
            m_active = 1'b1;
         end else begin
            m_txd    = 1'b1;
            m_active = 1'b0;
         end
      end
   end

   always @(negedge clk) begin
      if (m_ready) begin
         check("txd", txd, m_txd);
         check("busy", busy, m_active || (m_q.size() > 0));
         check("level", level, m_q.size());
         check("full", full, m_q.size() == DEPTH);
         check("overflow", ovf, m_ovf);
      end
   end

   byte unsigned burst_q[$];
   bit cap_txd [300];
   bit cap_busy[300];
   int peak, ovf_cnt, busy_cnt;

   // Writes burst_q on consecutive cycles starting at cycle N; cap_*[i] holds cycle N+i.
   task automatic run_capture(input int n);
      peak = 0; ovf_cnt = 0; busy_cnt = 0;
      @(negedge clk);
      valid = 1'b1;
      data  = burst_q.pop_front();
      for (int i = 1; i <= n; i++) begin
         @(negedge clk);
         if (burst_q.size() > 0) begin
            valid = 1'b1;
            data  = burst_q.pop_front();
         end else begin
            valid = 1'b0;
         end
         cap_txd[i]  = txd;
         cap_busy[i] = busy;
         if (int'(level) > peak) peak = int'(level);
         if (ovf) ovf_cnt++;
         if (busy) busy_cnt++;
      end
   endtask

   initial begin
      int a5_pat[8] = '{1, 0, 1, 0, 0, 1, 0, 1};
      int lows;

      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (100) begin
         @(negedge clk);
         check("idle_txd", txd, 1);
         check("idle_busy", busy, 0);
         check("idle_level", level, 0);
      end

      burst_q = '{8'hA5};
      run_capture(FRAME + 6);
      check("a5_pre", cap_txd[1], 1);
      for (int i = 2; i <= 5; i++) check("a5_start", cap_txd[i], 0);
      for (int b = 0; b < 8; b++)
         for (int k = 0; k < CPB; k++) check("a5_data", cap_txd[6 + b * CPB + k], a5_pat[b]);
`ifdef UART_TX_PARITY_EN
      for (int k = 0; k < CPB; k++) check("a5_parity", cap_txd[38 + k], 0);
`endif
      for (int k = 0; k < NSTOP * CPB; k++) check("a5_stop", cap_txd[38 + NPAR * CPB + k], 1);
      check("a5_busy_last", cap_busy[FRAME + 1], 1);
      check("a5_busy_drop", cap_busy[FRAME + 2], 0);
      check("a5_busy_len", busy_cnt, FRAME + 1);

      burst_q = '{8'h01, 8'h02, 8'h03};
      run_capture(3 * FRAME + 8);
      check("b2b_peak", peak, 2);
      for (int f = 0; f < 3; f++) begin
         check("b2b_start", cap_txd[2 + f * FRAME], 0);
         check("b2b_stop", cap_txd[1 + (f + 1) * FRAME], 1);
      end
      check("b2b_busy_len", busy_cnt, 3 * FRAME + 1);

      for (int i = 0; i < 6; i++) burst_q.push_back(8'($urandom));
      run_capture(5 * FRAME + 8);
      check("ovf_peak", peak, 4);
      check("ovf_pulses", ovf_cnt, 1);
      check("ovf_busy_len", busy_cnt, 5 * FRAME + 1);
      for (int f = 0; f < 5; f++) check("ovf_start", cap_txd[2 + f * FRAME], 0);

      burst_q = '{8'h00, 8'h00};
      run_capture(10);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("rst_txd", txd, 1);
      check("rst_level", level, 0);
      check("rst_busy", busy, 0);
      lows = 0;
      repeat (2 * FRAME) begin
         @(negedge clk);
         if (!txd) lows++;
      end
      check("rst_no_frame", lows, 0);

`ifdef UART_TX_PARITY_EN
      burst_q = '{8'h07};
      run_capture(FRAME + 6);
      check("par07_bit", cap_txd[38], 1);
      check("par07_len", busy_cnt, 11 * CPB + 1);
      burst_q = '{8'h03};
      run_capture(FRAME + 6);
      check("par03_bit", cap_txd[38], 0);
      check("par03_len", busy_cnt, 11 * CPB + 1);
`endif

      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         rst   = ($urandom_range(0, 999) == 0);
         valid = ($urandom_range(0, 99) < ((c / 500) % 2 == 0 ? 8 : 60));
         data  = 8'($urandom);
      end
      @(negedge clk);
      rst   = 1'b0;
      valid = 1'b0;
      repeat ((DEPTH + 2) * FRAME) @(negedge clk);
      check("drain_busy", busy, 0);
      check("drain_txd", txd, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
